mem_port_arbiter: RTL and testbench

//  Shares the single external memory port between instruction fetch (IF) and

---
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and data access
//
// Purpose: arbitrates the single external memory port between the fetch
// requester (IF) and the load/store requester (DM). DM normally wins. A
// streak limit guarantees IF service while it waits, and a timeout aborts a
// memory cycle that is never acknowledged.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   i_if_req, i_if_addr         fetch request (held until o_if_done)
//   o_if_done                   1-cycle fetch completion pulse
//   i_dm_req, i_dm_wr_en,
//   i_dm_addr, i_dm_wr_data     data request (held until o_dm_done)
//   o_dm_done                   1-cycle data completion pulse
//   o_rd_data                   registered read data, valid with a done pulse
//   o_bus_err                   pulses with the done of an aborted access
//   o_mem_req, o_mem_wr_en,
//   o_mem_addr, o_mem_wr_data   memory request, held until i_mem_ack
//   i_mem_ack, i_mem_rd_data    memory completion and read data
module mem_port_arbiter #(
  parameter int DATA_WIDTH_P      = 32,
  parameter int DATA_ADDR_WIDTH_P = 32,
  parameter int MAX_DM_STREAK_P   = 4,
  parameter int TIMEOUT_P         = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_if_req,
  input  logic [DATA_ADDR_WIDTH_P-1:0] i_if_addr,
  output logic                         o_if_done,
  input  logic                         i_dm_req,
  input  logic                         i_dm_wr_en,
  input  logic [DATA_ADDR_WIDTH_P-1:0] i_dm_addr,
  input  logic [DATA_WIDTH_P-1:0]      i_dm_wr_data,
  output logic                         o_dm_done,
  output logic [DATA_WIDTH_P-1:0]      o_rd_data,
  output logic                         o_bus_err,
  output logic                         o_mem_req,
  output logic                         o_mem_wr_en,
  output logic [DATA_ADDR_WIDTH_P-1:0] o_mem_addr,
  output logic [DATA_WIDTH_P-1:0]      o_mem_wr_data,
  input  logic                         i_mem_ack,
  input  logic [DATA_WIDTH_P-1:0]      i_mem_rd_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  localparam logic [3:0] STREAK_MAX   = 4'(MAX_DM_STREAK_P);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_P - 1);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] streak_q;
  logic [7:0] tcnt_q;

  logic if_elig;
  logic dm_elig;
  logic grant_if;
  logic grant_dm;
  logic busy;
  logic ack_hit;
  logic tmo_hit;

  // A requester whose done pulse is high is still holding its old request,
  // so it must not be granted again in that cycle.
  always_comb begin
    if_elig  = i_if_req && !o_if_done;
    dm_elig  = i_dm_req && !o_dm_done;
    busy     = (state_q != IDLE);
    grant_dm = (state_q == IDLE) && dm_elig && (!if_elig || (streak_q != STREAK_MAX));
    grant_if = (state_q == IDLE) && if_elig && !grant_dm;
    ack_hit  = busy && i_mem_ack;
    // An ack in the final timeout cycle takes priority over the abort.
    tmo_hit  = busy && !i_mem_ack && (tcnt_q == TIMEOUT_LAST);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_dm) begin
          state_d = BUSY_DM;
        end else if (grant_if) begin
          state_d = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (ack_hit || tmo_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      streak_q      <= '0;
      tcnt_q        <= '0;
      o_if_done     <= 1'b0;
      o_dm_done     <= 1'b0;
      o_bus_err     <= 1'b0;
      o_rd_data     <= '0;
      o_mem_req     <= 1'b0;
      o_mem_wr_en   <= 1'b0;
      o_mem_addr    <= '0;
      o_mem_wr_data <= '0;
    end else begin
      o_if_done <= 1'b0;
      o_dm_done <= 1'b0;
      o_bus_err <= 1'b0;
      if (grant_dm || grant_if) begin
        o_mem_req     <= 1'b1;
        o_mem_addr    <= grant_dm ? i_dm_addr : i_if_addr;
        o_mem_wr_en   <= grant_dm && i_dm_wr_en;
        o_mem_wr_data <= grant_dm ? i_dm_wr_data : '0;
        tcnt_q        <= '0;
        // Streak counts DM wins taken while fetch was asking for the port.
        if (grant_dm && i_if_req) begin
          if (streak_q != STREAK_MAX) begin
            streak_q <= streak_q + 4'd1;
          end
        end else begin
          streak_q <= '0;
        end
      end else if (ack_hit) begin
        o_mem_req <= 1'b0;
        o_rd_data <= i_mem_rd_data;
        o_if_done <= (state_q == BUSY_IF);
        o_dm_done <= (state_q == BUSY_DM);
      end else if (tmo_hit) begin
        o_mem_req <= 1'b0;
        o_rd_data <= '0;
        o_bus_err <= 1'b1;
        o_if_done <= (state_q == BUSY_IF);
        o_dm_done <= (state_q == BUSY_DM);
      end else if (busy) begin
        tcnt_q <= tcnt_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int MAXS = 4;
  localparam int TMO  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_done;
  logic          dm_req;
  logic          dm_wr_en;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wr_data;
  logic          dm_done;
  logic [DW-1:0] rd_data;
  logic          bus_err;
  logic          mem_req;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_ack;
  logic [DW-1:0] mem_rd_data;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .DATA_WIDTH_P(DW), .DATA_ADDR_WIDTH_P(AW),
    .MAX_DM_STREAK_P(MAXS), .TIMEOUT_P(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_done(if_done),
    .i_dm_req(dm_req), .i_dm_wr_en(dm_wr_en), .i_dm_addr(dm_addr),
    .i_dm_wr_data(dm_wr_data), .o_dm_done(dm_done),
    .o_rd_data(rd_data), .o_bus_err(bus_err),
    .o_mem_req(mem_req), .o_mem_wr_en(mem_wr_en), .o_mem_addr(mem_addr),
    .o_mem_wr_data(mem_wr_data), .i_mem_ack(mem_ack), .i_mem_rd_data(mem_rd_data)
  );

  // Behavioural model: which requester owns the port, how many cycles it has
  // waited, and the outputs the rules say must be visible this cycle.
  bit            m_busy;
  bit            m_own_dm;
  int            m_streak;
  int            m_wait;
  logic          e_if_done, e_dm_done, e_bus_err, e_mem_req, e_wr_en;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rd;
  bit            e_rd_known;

  int n_cmp = 0;
  int n_bad = 0;
  bit armed = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit if_el, dm_el;
    if (reset) begin
      m_busy = 0; m_own_dm = 0; m_streak = 0; m_wait = 0;
      e_if_done = 0; e_dm_done = 0; e_bus_err = 0; e_mem_req = 0; e_wr_en = 0;
      e_addr = '0; e_wdata = '0; e_rd = '0; e_rd_known = 1;
    end else begin
      if_el = if_req && !e_if_done;
      dm_el = dm_req && !e_dm_done;
      e_if_done = 0; e_dm_done = 0; e_bus_err = 0;
      if (!m_busy) begin
        if (dm_el && !(if_el && m_streak == MAXS)) begin
          m_busy = 1; m_own_dm = 1; m_wait = 0; e_mem_req = 1;
          e_addr = dm_addr; e_wr_en = dm_wr_en; e_wdata = dm_wr_data;
          m_streak = if_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
        end else if (if_el) begin
          m_busy = 1; m_own_dm = 0; m_wait = 0; e_mem_req = 1;
          e_addr = if_addr; e_wr_en = 0;
          m_streak = 0;
        end
      end else if (mem_ack) begin
        m_busy = 0; e_mem_req = 0;
        e_rd = mem_rd_data;
        e_rd_known = !(m_own_dm && e_wr_en);
        e_dm_done = m_own_dm; e_if_done = !m_own_dm;
      end else begin
        m_wait++;
        if (m_wait == TMO) begin
          m_busy = 0; e_mem_req = 0; e_bus_err = 1;
          e_rd = '0; e_rd_known = 1;
          e_dm_done = m_own_dm; e_if_done = !m_own_dm;
        end
      end
    end
  endtask

  // Inputs are held across the edge, so the model sees exactly what the DUT saw.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clr();
    reset = 0; if_req = 0; if_addr = '0; dm_req = 0; dm_wr_en = 0;
    dm_addr = '0; dm_wr_data = '0; mem_ack = 0; mem_rd_data = '0;
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("if_done", if_done, e_if_done);
      chk("dm_done", dm_done, e_dm_done);
      chk("bus_err", bus_err, e_bus_err);
      chk("mem_req", mem_req, e_mem_req);
      if (e_rd_known) chk("rd_data", rd_data, e_rd);
      if (e_mem_req) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wr_en", mem_wr_en, e_wr_en);
        if (e_wr_en) chk("mem_wr_data", mem_wr_data, e_wdata);
      end
    end
  end

  initial begin
    int ack_pct;
    clr();
    reset = 1;
    step(); step();
    armed = 1;
    chk("rst_outs", {if_done, dm_done, bus_err, mem_req, mem_wr_en}, 5'b0);
    chk("rst_rd", rd_data, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);

    // Single fetch, ack one cycle after the request appears.
    clr(); if_req = 1; if_addr = 32'h10; step();
    chk("t1_req", mem_req, 1); chk("t1_addr", mem_addr, 32'h10); chk("t1_wr", mem_wr_en, 0);
    step();
    mem_ack = 1; mem_rd_data = 32'hDEADBEEF; step();
    chk("t1_done", if_done, 1); chk("t1_rd", rd_data, 32'hDEADBEEF); chk("t1_req_drop", mem_req, 0);
    clr(); step();
    chk("t1_pulse", if_done, 0);

    // Simultaneous requests: DM store first, IF right after the done cycle.
    clr(); if_req = 1; if_addr = 32'h20;
    dm_req = 1; dm_wr_en = 1; dm_addr = 32'h80; dm_wr_data = 32'h55; step();
    chk("t2_wr", mem_wr_en, 1); chk("t2_addr", mem_addr, 32'h80); chk("t2_wdata", mem_wr_data, 32'h55);
    mem_ack = 1; step();
    chk("t2_dm_done", dm_done, 1); chk("t2_idle", mem_req, 0);
    dm_req = 0; mem_ack = 0; step();
    chk("t2_if_req", mem_req, 1); chk("t2_if_addr", mem_addr, 32'h20); chk("t2_if_wr", mem_wr_en, 0);
    mem_ack = 1; step();
    chk("t2_if_done", if_done, 1);
    clr(); step();

    // Streak limit: four DM wins with IF asking, then IF, then DM again.
    for (int k = 0; k < 6; k++) begin
      clr(); if_req = 1; if_addr = 32'h200;
      dm_req = 1; dm_wr_en = 1; dm_addr = 32'h100 + k; dm_wr_data = k; step();
      chk("t3_winner", mem_addr, (k == 4) ? 32'h200 : 32'h100 + k);
      mem_ack = 1; mem_rd_data = 32'hA5A5A5A5; step();
      clr(); step();
    end

    // Timeout on a load: request high TMO cycles, then done with error.
    clr(); dm_req = 1; dm_addr = 32'h300; step();
    for (int i = 0; i < TMO; i++) begin
      chk("t4_req_held", mem_req, 1);
      if (i < TMO - 1) step();
    end
    step();
    chk("t4_done", dm_done, 1); chk("t4_err", bus_err, 1);
    chk("t4_rd", rd_data, 32'h0); chk("t4_drop", mem_req, 0);
    clr(); step();

    // Ack arriving in the timeout cycle wins.
    clr(); dm_req = 1; dm_addr = 32'h340; step();
    for (int i = 0; i < TMO - 1; i++) step();
    mem_ack = 1; mem_rd_data = 32'h12345678; step();
    chk("t6_done", dm_done, 1); chk("t6_err", bus_err, 0); chk("t6_rd", rd_data, 32'h12345678);
    clr(); step();

    // Reset while busy, late ack ignored, next fetch works.
    clr(); dm_req = 1; dm_addr = 32'h400; step();
    step();
    reset = 1; step();
    chk("t5_req", mem_req, 0); chk("t5_nodone", dm_done, 0);
    clr(); mem_ack = 1; step();
    chk("t5_late", {dm_done, if_done, bus_err, mem_req}, 4'b0);
    clr(); if_req = 1; if_addr = 32'h500; step();
    chk("t5_if_addr", mem_addr, 32'h500);
    mem_ack = 1; mem_rd_data = 32'hCAFEF00D; step();
    chk("t5_if_done", if_done, 1); chk("t5_rd", rd_data, 32'hCAFEF00D);
    clr(); step();

    // Randomized traffic against the model.
    ack_pct = 30;
    for (int c = 0; c < 4000; c++) begin
      if (c % 100 == 0) begin
        case ($urandom_range(0, 3))
          0: ack_pct = 0;
          1: ack_pct = 5;
          2: ack_pct = 30;
          default: ack_pct = 80;
        endcase
      end
      reset       = ($urandom_range(0, 299) == 0);
      if_req      = ($urandom_range(0, 99) < 60);
      if_addr     = $urandom;
      dm_req      = ($urandom_range(0, 99) < 70);
      dm_wr_en    = $urandom_range(0, 1);
      dm_addr     = $urandom;
      dm_wr_data  = $urandom;
      mem_ack     = ($urandom_range(0, 99) < ack_pct);
      mem_rd_data = $urandom;
      step();
    end

    clr(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
